// File: rtl/ddr3_read_capture_ctrl.sv
// Read-side capture controller for an 8-deep DDR3 strobe ring buffer: waits CAS latency,
// arms the buffer for one burst, sweeps it into a 128-bit word and returns it with its tag.
module ddr3_read_capture_ctrl #(
   parameter int unsigned CL     = 5,
   parameter int unsigned SETTLE = 6,
   parameter int unsigned TAG_W  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_issue,
   input  logic [TAG_W-1:0] rd_tag_in,
   output logic             issue_ready,
   output logic             listen,
   output logic [2:0]       readPtr,
   input  logic [15:0]      din,
   output logic [127:0]     rd_data,
   output logic [TAG_W-1:0] rd_tag_out,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic             err_overrun
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LAT    = 3'd1;
   localparam logic [2:0] S_LISTEN = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_READ   = 3'd4;
   localparam logic [2:0] S_VALID  = 3'd5;

   localparam logic [3:0] CL_LAST     = 4'(CL - 1);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   logic [2:0]       state_q,   state_d;
   logic [3:0]       cnt_q,     cnt_d;
   logic [TAG_W-1:0] tag_q,     tag_d;
   logic             listen_q,  listen_d;
   logic [2:0]       ptr_q,     ptr_d;
   logic [127:0]     data_q,    data_d;
   logic [TAG_W-1:0] tag_out_q, tag_out_d;
   logic             valid_q,   valid_d;
   logic             err_q,     err_d;

   // Next-state and output-register decode; din is only looked at while sweeping.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tag_d     = tag_q;
      listen_d  = listen_q;
      ptr_d     = ptr_q;
      data_d    = data_q;
      tag_out_d = tag_out_q;
      valid_d   = valid_q;
      err_d     = err_q | (rd_issue & (state_q != S_IDLE));

      case (state_q)
         S_IDLE: begin
            if (rd_issue) begin
               tag_d   = rd_tag_in;
               cnt_d   = 4'd0;
               state_d = S_LAT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAT: begin
            if (cnt_q == CL_LAST) begin
               listen_d = 1'b1;
               cnt_d    = 4'd0;
               state_d  = S_LISTEN;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_LISTEN: begin
            listen_d = 1'b0;
            cnt_d    = 4'd0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = 4'd0;
               ptr_d   = 3'd0;
               state_d = S_READ;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_READ: begin
            data_d[{ptr_q, 4'b0000} +: 16] = din;
            if (ptr_q == 3'd7) begin
               ptr_d     = 3'd0;
               valid_d   = 1'b1;
               tag_out_d = tag_q;
               state_d   = S_VALID;
            end else begin
               ptr_d = ptr_q + 3'd1;
            end
         end
         S_VALID: begin
            if (rd_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            listen_d = 1'b0;
            ptr_d    = 3'd0;
            valid_d  = 1'b0;
            cnt_d    = 4'd0;
         end
      endcase
   end

   // State and output registers; reset discards any burst in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 4'd0;
         tag_q     <= '0;
         listen_q  <= 1'b0;
         ptr_q     <= 3'd0;
         data_q    <= 128'd0;
         tag_out_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tag_q     <= tag_d;
         listen_q  <= listen_d;
         ptr_q     <= ptr_d;
         data_q    <= data_d;
         tag_out_q <= tag_out_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign issue_ready = (state_q == S_IDLE);
   assign listen      = listen_q;
   assign readPtr     = ptr_q;
   assign rd_data     = data_q;
   assign rd_tag_out  = tag_out_q;
   assign rd_valid    = valid_q;
   assign err_overrun = err_q;

endmodule

// File: tb/tb_ddr3_read_capture_ctrl.sv
// Directed bench for ddr3_read_capture_ctrl with a combinational ring-buffer model on din.
module tb_ddr3_read_capture_ctrl;

   logic         clk = 1'b0;
   logic         reset;
   logic         rd_issue;
   logic [3:0]   rd_tag_in;
   logic         issue_ready;
   logic         listen;
   logic [2:0]   readPtr;
   logic [15:0]  din;
   logic [127:0] rd_data;
   logic [3:0]   rd_tag_out;
   logic         rd_valid;
   logic         rd_ready;
   logic         err_overrun;

   logic [15:0]  beat_base;
   int           checks = 0;
   int           errors = 0;

   ddr3_read_capture_ctrl #(.CL(5), .SETTLE(6), .TAG_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .rd_issue    (rd_issue),
      .rd_tag_in   (rd_tag_in),
      .issue_ready (issue_ready),
      .listen      (listen),
      .readPtr     (readPtr),
      .din         (din),
      .rd_data     (rd_data),
      .rd_tag_out  (rd_tag_out),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   // Ring buffer model: beat k reads back as beat_base + k.
   assign din = beat_base + {13'd0, readPtr};

   function automatic logic [127:0] burst(input logic [15:0] base);
      logic [127:0] w;
      w = 128'd0;
      for (int k = 0; k < 8; k++) w[16*k +: 16] = base + 16'(k);
      return w;
   endfunction

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives rd_issue for exactly one edge (that edge is E0).
   task automatic issue(input logic [3:0] tag);
      rd_issue  = 1'b1;
      rd_tag_in = tag;
      tick();
      rd_issue  = 1'b0;
      rd_tag_in = 4'h0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   initial begin
      logic [127:0] exp_w;
      logic [127:0] held_w;
      bit           done;
      int           accepted;

      reset     = 1'b1;
      rd_issue  = 1'b0;
      rd_tag_in = 4'h0;
      rd_ready  = 1'b0;
      beat_base = 16'h0000;
      #2;
      chk("rst_data", rd_data, 128'd0);
      chk("rst_valid", rd_valid, 1'b0);
      do_reset();

      // Reset then idle
      for (int n = 0; n < 10; n++) tick();
      chk("idle_ready", issue_ready, 1'b1);
      chk("idle_listen", listen, 1'b0);
      chk("idle_ptr", readPtr, 3'd0);
      chk("idle_valid", rd_valid, 1'b0);
      chk("idle_err", err_overrun, 1'b0);
      chk("idle_tag", rd_tag_out, 4'h0);

      // Single read, rd_ready held high
      beat_base = 16'h1000;
      rd_ready  = 1'b1;
      exp_w     = burst(16'h1000);
      issue(4'hA);
      chk("s_ready_e0", issue_ready, 1'b0);
      for (int n = 1; n <= 22; n++) begin
         tick();
         chk($sformatf("s_listen_e%0d", n), listen, (n == 5));
         chk($sformatf("s_ptr_e%0d", n), readPtr, (n >= 12 && n <= 19) ? 3'(n - 12) : 3'd0);
         chk($sformatf("s_valid_e%0d", n), rd_valid, (n == 20));
         chk($sformatf("s_ready_e%0d", n), issue_ready, (n >= 21));
         if (n == 20) begin
            chk("s_data", rd_data, exp_w);
            chk("s_tag", rd_tag_out, 4'hA);
         end
      end
      chk("s_err", err_overrun, 1'b0);

      // Backpressure: rd_ready only at E30
      beat_base = 16'h2000;
      rd_ready  = 1'b0;
      exp_w     = burst(16'h2000);
      issue(4'h6);
      for (int n = 1; n <= 31; n++) begin
         rd_ready = (n == 30);
         tick();
         if (n >= 20 && n <= 29) begin
            chk($sformatf("bp_valid_e%0d", n), rd_valid, 1'b1);
            chk($sformatf("bp_data_e%0d", n), rd_data, exp_w);
            chk($sformatf("bp_tag_e%0d", n), rd_tag_out, 4'h6);
            chk($sformatf("bp_ready_e%0d", n), issue_ready, 1'b0);
         end else if (n >= 30) begin
            chk($sformatf("bp_valid_e%0d", n), rd_valid, 1'b0);
            chk($sformatf("bp_ready_e%0d", n), issue_ready, 1'b1);
         end else begin
            chk($sformatf("bp_valid_e%0d", n), rd_valid, 1'b0);
         end
      end
      rd_ready = 1'b0;

      // Overrun: second issue (tag 3) at E8 is dropped
      beat_base = 16'h5A00;
      rd_ready  = 1'b1;
      exp_w     = burst(16'h5A00);
      issue(4'hA);
      for (int n = 1; n <= 22; n++) begin
         if (n == 8) begin
            rd_issue  = 1'b1;
            rd_tag_in = 4'h3;
         end
         tick();
         rd_issue  = 1'b0;
         rd_tag_in = 4'h0;
         chk($sformatf("ov_listen_e%0d", n), listen, (n == 5));
         if (n <= 7) chk($sformatf("ov_err_e%0d", n), err_overrun, 1'b0);
         if (n >= 9) chk($sformatf("ov_err_e%0d", n), err_overrun, 1'b1);
         chk($sformatf("ov_valid_e%0d", n), rd_valid, (n == 20));
         if (n == 20) begin
            chk("ov_tag", rd_tag_out, 4'hA);
            chk("ov_data", rd_data, exp_w);
         end
      end
      for (int n = 0; n < 12; n++) begin
         tick();
         chk("ov_no_listen", listen, 1'b0);
      end
      chk("ov_err_sticky", err_overrun, 1'b1);

      // Mid-burst reset during beat 3
      do_reset();
      chk("rst_clears_err", err_overrun, 1'b0);
      beat_base = 16'h7700;
      issue(4'hC);
      for (int n = 1; n <= 15; n++) tick();
      chk("mb_ptr_before", readPtr, 3'd3);
      reset = 1'b1;
      #1;
      chk("mb_ptr", readPtr, 3'd0);
      chk("mb_listen", listen, 1'b0);
      chk("mb_valid", rd_valid, 1'b0);
      chk("mb_data", rd_data, 128'd0);
      chk("mb_tag", rd_tag_out, 4'h0);
      chk("mb_err", err_overrun, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      for (int n = 0; n < 15; n++) begin
         tick();
         chk("mb_no_valid", rd_valid, 1'b0);
         chk("mb_idle_ready", issue_ready, 1'b1);
      end
      beat_base = 16'h3000;
      exp_w     = burst(16'h3000);
      issue(4'h5);
      for (int n = 1; n <= 20; n++) tick();
      chk("mb_new_valid", rd_valid, 1'b1);
      chk("mb_new_data", rd_data, exp_w);
      chk("mb_new_tag", rd_tag_out, 4'h5);
      tick();

      // Back-to-back reads, tags 1..3, random rd_ready
      accepted = 0;
      for (int t = 1; t <= 3; t++) begin
         done = 1'b0;
         for (int w = 0; w < 50 && !issue_ready; w++) tick();
         chk($sformatf("bb_issue_ready_%0d", t), issue_ready, 1'b1);
         beat_base = 16'h4000 + 16'(t * 16'h0100);
         exp_w     = burst(beat_base);
         issue(4'(t));
         for (int c = 0; c < 200 && !done; c++) begin
            rd_ready = 1'($urandom_range(0, 1));
            if (rd_valid && rd_ready) begin
               held_w = rd_data;
               chk($sformatf("bb_tag_%0d", t), rd_tag_out, 4'(t));
               chk($sformatf("bb_data_%0d", t), held_w, exp_w);
               accepted++;
               done = 1'b1;
            end
            tick();
         end
         chk($sformatf("bb_done_%0d", t), done, 1'b1);
         rd_ready = 1'b0;
         chk($sformatf("bb_after_valid_%0d", t), rd_valid, 1'b0);
      end
      chk("bb_count", 32'(accepted), 32'd3);
      chk("bb_err", err_overrun, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
